// File: rtl/sobel_window_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_pkg : shared constants and window indexing for the Sobel datapath    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sobel_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int IMG_W_DEFAULT = 640;
  localparam int IMG_H_DEFAULT = 480;
  localparam int WIN_TAPS      = 9;

  // Flat tap index of window row r (0 = oldest line), column c (0 = oldest column).
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_window_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_gen_if : pixel stream in, packed 3x3 window out               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sobel_window_gen_if #(
  parameter int DW = sobel_pkg::DW_DEFAULT
);

  logic [DW-1:0]                    i_data;
  logic                             i_valid;
  logic                             i_sof;
  logic [sobel_pkg::WIN_TAPS*DW-1:0] o_data;
  logic                             o_valid;
  logic                             o_eof;

  modport master (
    output i_data, i_valid, i_sof,
    input  o_data, o_valid, o_eof
  );

  modport slave (
    input  i_data, i_valid, i_sof,
    output o_data, o_valid, o_eof
  );

endinterface
`default_nettype wire

// File: rtl/sobel_window_gen_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_buffer : one image line of storage, async read, sync write            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = IMG_W_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are never reset; the top gates out rows that are not yet valid.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_gen : raster stream to 3x3 interior-window generator          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  sobel_window_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WB = WIN_TAPS * DW;

  logic [1:0]    rst_sync_q;
  logic          rst_n;

  logic [CW-1:0] col_q, col_d, acc_col;
  logic [RW-1:0] row_q, row_d, acc_row;
  logic [WB-1:0] win_q, win_d;
  logic          valid_q, valid_d;
  logic          eof_q, eof_d;
  logic          win_ok;
  logic          frame_last;
  logic [DW-1:0] lb1_rd;
  logic [DW-1:0] lb2_rd;

  // Reset asserts immediately but releases two clocks later, in step with i_clk.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Coordinates of the pixel being accepted this cycle; i_sof pins it to (0,0).
  always_comb begin
    acc_col = bus.i_sof ? '0 : col_q;
    acc_row = bus.i_sof ? '0 : row_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.i_valid) begin
      if (acc_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (acc_row == RW'(IMG_H - 1)) ? '0 : acc_row + 1'b1;
      end else begin
        col_d = acc_col + 1'b1;
        row_d = acc_row;
      end
    end
  end

  assign win_ok     = (acc_row >= RW'(2)) && (acc_col >= CW'(2));
  assign frame_last = (acc_row == RW'(IMG_H - 1)) && (acc_col == CW'(IMG_W - 1));
  assign valid_d    = bus.i_valid & win_ok;
  assign eof_d      = bus.i_valid & win_ok & frame_last;

  // lb1 holds the previous line; lb2 receives what lb1 is about to overwrite.
  line_buffer #(
    .DW    (DW),
    .DEPTH (IMG_W)
  ) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (bus.i_valid),
    .i_addr  (acc_col),
    .i_wdata (bus.i_data),
    .o_rdata (lb1_rd)
  );

  line_buffer #(
    .DW    (DW),
    .DEPTH (IMG_W)
  ) u_lb2 (
    .i_clk   (i_clk),
    .i_we    (bus.i_valid),
    .i_addr  (acc_col),
    .i_wdata (lb1_rd),
    .o_rdata (lb2_rd)
  );

  always_comb begin
    win_d = win_q;
    if (bus.i_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[win_idx(r, 0)*DW +: DW] = win_q[win_idx(r, 1)*DW +: DW];
        win_d[win_idx(r, 1)*DW +: DW] = win_q[win_idx(r, 2)*DW +: DW];
      end
      win_d[win_idx(0, 2)*DW +: DW] = lb2_rd;
      win_d[win_idx(1, 2)*DW +: DW] = lb1_rd;
      win_d[win_idx(2, 2)*DW +: DW] = bus.i_data;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
    end
  end

  assign bus.o_data  = win_q;
  assign bus.o_valid = valid_q;
  assign bus.o_eof   = eof_q;

endmodule
`default_nettype wire
